// File: rtl/booth_pkg.sv
// booth_pkg: state and digit-select encodings plus digit-count helper shared by the Booth multiplier
package booth_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CALC = 1'b1;
  typedef enum logic [2:0] {SEL_ZERO, SEL_POS1, SEL_POS2, SEL_NEG1, SEL_NEG2} digit_sel_t;
  // Unsigned operands need one extra digit so the zero-extended top window stays non-negative.
  function automatic int num_digits(input int width, input logic signed_mode);
    return signed_mode ? width / 2 : width / 2 + 1;
  endfunction
endpackage

// File: rtl/booth_recoder.sv
// booth_recoder: maps a radix-4 Booth window {x[2i+1], x[2i], x[2i-1]} to digit flags
//   window  in  3  Booth window, msb first
//   neg     out 1  digit is negative
//   two     out 1  digit magnitude is 2 (else 1 or 0)
//   zero    out 1  digit is zero
module booth_recoder
  import booth_pkg::*;
(
  input  logic [2:0] window,
  output logic       neg,
  output logic       two,
  output logic       zero
);
  digit_sel_t sel;
  always_comb
    sel = (window == 3'b000 || window == 3'b111) ? SEL_ZERO
        : (window == 3'b011) ? SEL_POS2
        : (window == 3'b100) ? SEL_NEG2
        : window[2] ? SEL_NEG1 : SEL_POS1;
  assign zero = (sel == SEL_ZERO);
  assign two  = (sel == SEL_POS2) || (sel == SEL_NEG2);
  assign neg  = (sel == SEL_NEG1) || (sel == SEL_NEG2);
endmodule

// File: rtl/booth_radix4_mult.sv
// booth_radix4_mult: iterative radix-4 Booth multiplier, one digit per clock, signed or unsigned
//   clock        in  1        rising-edge clock
//   reset_n      in  1        asynchronous active-low reset
//   start        in  1        request, sampled only while idle
//   signed_mode  in  1        1 = two's complement operands, 0 = unsigned
//   x_value      in  WIDTH    multiplier (Booth-recoded)
//   y_value      in  WIDTH    multiplicand
//   product      out 2*WIDTH  result, held until the next completion
//   busy         out 1        high while an operation is in flight
//   done         out 1        one-cycle completion pulse
module booth_radix4_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   x_value,
  input  logic [WIDTH-1:0]   y_value,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);
  localparam int ITW = $clog2(WIDTH / 2 + 2);
  if (WIDTH < 4 || WIDTH % 2 != 0) begin : g_width_check
    $error("booth_radix4_mult: WIDTH must be even and >= 4");
  end
  logic [0:0]         state;
  logic [ITW-1:0]     iter;
  logic [ITW-1:0]     last;
  // Multiplier with two extension bits on top and the implicit x[-1]=0 at bit 0;
  // it shifts right by two per digit so the current window is always xs[2:0].
  logic [WIDTH+2:0]   xs;
  // Multiplicand pre-shifted by 2i, so each partial product is added unshifted.
  logic [2*WIDTH-1:0] ys;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] term;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_next;
  logic               neg;
  logic               two;
  logic               zero;
  booth_recoder u_recoder (
    .window (xs[2:0]),
    .neg    (neg),
    .two    (two),
    .zero   (zero)
  );
  assign term     = zero ? '0 : (two ? {ys[2*WIDTH-2:0], 1'b0} : ys);
  assign addend   = neg ? ~term + 1'b1 : term;
  assign acc_next = acc + addend;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      iter    <= '0;
      last    <= '0;
      xs      <= '0;
      ys      <= '0;
      acc     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          xs    <= {{2{signed_mode & x_value[WIDTH-1]}}, x_value, 1'b0};
          ys    <= signed_mode ? {{WIDTH{y_value[WIDTH-1]}}, y_value} : {{WIDTH{1'b0}}, y_value};
          last  <= ITW'(num_digits(WIDTH, signed_mode) - 1);
          acc   <= '0;
          iter  <= '0;
          busy  <= 1'b1;
          state <= ST_CALC;
        end
      end else begin
        acc  <= acc_next;
        xs   <= {{2{xs[WIDTH+2]}}, xs[WIDTH+2:2]};
        ys   <= ys << 2;
        iter <= iter + 1'b1;
        if (iter == last) begin
          product <= acc_next;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_booth_radix4_mult.sv
// tb_booth_radix4_mult: directed and randomised self-checking bench for booth_radix4_mult
module tb_booth_radix4_mult;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  x_value = '0;
  logic [7:0]  y_value = '0;
  logic [15:0] product;
  logic        busy;
  logic        done;
  logic        start_w = 1'b0;
  logic        signed_w = 1'b0;
  logic [15:0] x_w = '0;
  logic [15:0] y_w = '0;
  logic [31:0] product_w;
  logic        busy_w;
  logic        done_w;
  int total = 0;
  int bad = 0;
  always #5 clock = ~clock;
  booth_radix4_mult #(.WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .signed_mode(signed_mode),
    .x_value(x_value), .y_value(y_value), .product(product), .busy(busy), .done(done)
  );
  booth_radix4_mult #(.WIDTH(16)) dut_w (
    .clock(clock), .reset_n(reset_n), .start(start_w), .signed_mode(signed_w),
    .x_value(x_w), .y_value(y_w), .product(product_w), .busy(busy_w), .done(done_w)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic launch8(input logic sm, input logic [7:0] x, input logic [7:0] y);
    signed_mode = sm;
    x_value = x;
    y_value = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait8(input string tag, input int n0, input int lat, input logic [15:0] exp);
    int n = n0;
    int nb = n0;
    while (!done && n < 64) begin
      if (busy) nb++;
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " busy cycles"}, 64'(nb), 64'(lat));
    check({tag, " product"}, 64'(product), 64'(exp));
    check({tag, " busy at done"}, 64'(busy), 64'(0));
    tick();
    check({tag, " done cleared"}, 64'(done), 64'(0));
  endtask
  task automatic run16(input string tag, input logic sm, input logic [15:0] x, input logic [15:0] y,
                       input int lat, input logic [31:0] exp);
    int n = 0;
    signed_w = sm;
    x_w = x;
    y_w = y;
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    while (!done_w && n < 64) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " product"}, 64'(product_w), 64'(exp));
    tick();
    check({tag, " done cleared"}, 64'(done_w), 64'(0));
  endtask
  initial begin
    int n;
    int nd;
    logic sm;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] e;
    #2;
    check("reset product", 64'(product), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("idle busy", 64'(busy), 64'(0));
    launch8(1'b0, 8'd255, 8'd255);
    wait8("u255x255", 0, 5, 16'hFE01);
    launch8(1'b1, 8'h80, 8'h80);
    wait8("s-128x-128", 0, 4, 16'h4000);
    launch8(1'b1, 8'h80, 8'h7F);
    wait8("s-128x127", 0, 4, 16'hC080);
    launch8(1'b1, 8'h01, 8'h80);
    wait8("s1x-128", 0, 4, 16'hFF80);
    launch8(1'b1, 8'hFF, 8'h01);
    wait8("s-1x1", 0, 4, 16'hFFFF);
    launch8(1'b0, 8'd0, 8'd200);
    wait8("u0x200", 0, 5, 16'h0000);
    launch8(1'b0, 8'd128, 8'd2);
    wait8("u128x2", 0, 5, 16'h0100);
    signed_mode = 1'b0;
    x_value = 8'd3;
    y_value = 8'd5;
    start = 1'b1;
    n = 0;
    while (!done && n < 64) begin
      tick();
      n++;
    end
    check("b2b first latency", 64'(n), 64'(6));
    check("b2b first product", 64'(product), 64'(15));
    repeat (2) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!done && n < 64);
      check("b2b period", 64'(n), 64'(6));
      check("b2b product", 64'(product), 64'(15));
    end
    start = 1'b0;
    tick();
    tick();
    check("b2b idle after", 64'(busy), 64'(0));
    launch8(1'b0, 8'd10, 8'd20);
    tick();
    tick();
    x_value = 8'd77;
    y_value = 8'd99;
    signed_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait8("mid change", 3, 5, 16'd200);
    nd = 0;
    repeat (8) begin
      tick();
      if (done) nd++;
    end
    check("no extra done", 64'(nd), 64'(0));
    check("product held", 64'(product), 64'(200));
    launch8(1'b1, 8'h7F, 8'h7F);
    tick();
    reset_n = 1'b0;
    #1;
    check("async rst busy", 64'(busy), 64'(0));
    check("async rst done", 64'(done), 64'(0));
    check("async rst product", 64'(product), 64'(0));
    tick();
    reset_n = 1'b1;
    tick();
    check("post rst busy", 64'(busy), 64'(0));
    check("post rst done", 64'(done), 64'(0));
    launch8(1'b1, 8'hFD, 8'h07);
    wait8("post rst s-3x7", 0, 4, 16'hFFEB);
    run16("u16 ffff^2", 1'b0, 16'hFFFF, 16'hFFFF, 9, 32'hFFFE0001);
    run16("s16 min^2", 1'b1, 16'h8000, 16'h8000, 8, 32'h40000000);
    for (int i = 0; i < 1000; i++) begin
      sm = 1'($urandom_range(1));
      a = 16'($urandom);
      b = 16'($urandom);
      e = sm ? {{16{a[15]}}, a} * {{16{b[15]}}, b} : {16'b0, a} * {16'b0, b};
      run16("sweep", sm, a, b, sm ? 8 : 9, e);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/booth_radix4_mult.md
Name: booth_radix4_mult

Overview:
Iterative, parametrised radix-4 Booth multiplier that retires one Booth digit per clock.
- Supports signed (two's complement) and unsigned operands, selected per operation.
- Operands are latched at start, so the requester may change its inputs while the block is busy.
- Used as a shared multiply resource behind a start/busy/done handshake; the product is held until the next operation completes.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4 (elaboration error otherwise).

Ports:
clock  in  1  rising-edge clock, the single clock of the block.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  request; sampled only in IDLE.
signed_mode  in  1  1 = signed operands, 0 = unsigned; latched with the operands.
x_value  in  WIDTH  multiplier (Booth-recoded operand).
y_value  in  WIDTH  multiplicand.
product  out  2*WIDTH  result; holds its value until the next completion.
busy  out  1  high from the start-acceptance edge until the edge that raises done.
done  out  1  one-cycle pulse; product is valid in the same cycle.

Behaviour:
- Reset: reset_n low forces state=IDLE and clears product, busy, done, iter and the accumulator immediately, without waiting for a clock edge. This applies mid-operation; the partial result is discarded.
- Deassertion of reset_n is synchronised externally. The first edge after release behaves as an IDLE edge.
- States:
  - IDLE: on start=1, latch x_value, y_value and signed_mode; clear acc and iter; busy<=1; go to CALC. With start=0, remain in IDLE.
  - CALC: each edge processes digit iter; iter<=iter+1.
  - On the last digit: product<=final acc, done<=1, busy<=0, go to IDLE.
- done is cleared on the next edge.
- There is no separate DONE state, so a start on the cycle done is high is accepted.
- Digit count D:
  - Signed: WIDTH/2.
  - Unsigned: WIDTH/2+1. The multiplier is zero-extended by 2 bits so the top digit is non-negative.
- Latency: start accepted at edge t0; done is high during the cycle after edge t0+D. Back-to-back throughput is one operation per D+1 cycles.
- Recoding: digit i uses bits {x[2i+1], x[2i], x[2i-1]}, with x[-1]=0. Bits above the operand width are sign bits (signed) or 0 (unsigned).
- Digit values by bit pattern:
  - 000 and 111 -> 0
  - 001 and 010 -> +Y
  - 011 -> +2Y
  - 100 -> -2Y
  - 101 and 110 -> -Y
- Arithmetic:
  - Y is extended to 2*WIDTH bits, by sign extension (signed) or zero extension (unsigned).
  - Each step adds acc <= acc + (digit*Y) << 2i.
  - acc is 2*WIDTH bits; arithmetic is modulo 2^(2*WIDTH). Intermediate wrap is permitted because the final exact product fits.
  - -Y is formed as ~Y+1 within 2*WIDTH bits.
- start while busy: ignored, with no effect on the latched operands or state.
- Input changes while busy: no effect on the result.
- Zero digits still consume a cycle, so latency is data-independent.
- product must not change except on the completion edge or on reset.

Decomposition:
- Shared package booth_pkg:
  - State encoding (IDLE, CALC).
  - Digit-select encoding (ZERO, POS1, POS2, NEG1, NEG2).
  - Function num_digits(WIDTH, signed_mode).
- Sub-module booth_recoder: purely combinational. Maps the 3-bit window to neg, two and zero flags. Instantiated once inside booth_radix4_mult.

Test Plan:
1. WIDTH=8, unsigned, x=255, y=255, start one cycle -> busy high 5 cycles; done pulse once; product=0xFE01 (65025).
2. WIDTH=8, signed, x=-128, y=-128 -> latency 4; product=0x4000.
3. WIDTH=8, signed, x=-1, y=1 -> product=0xFFFF; then unsigned x=0, y=200 -> product=0x0000.
4. Back-to-back: start held high continuously with x=3, y=5 unsigned -> done pulses every 6 cycles, product=15 each time.
5. Robustness:
   - Change x_value and y_value and pulse start mid-CALC -> result matches the originally latched operands; no extra done.
   - Drop reset_n low mid-CALC -> busy, done and product are 0 before the next clock edge.
6. WIDTH=16, unsigned, x=y=0xFFFF -> latency 9; product=0xFFFE0001. Also run a random signed/unsigned sweep of 1000 vectors against a reference model.
